nand_exerciser: RTL and testbench
=================================

NAND_EXERCISER -- requirements
Module: nand_exerciser

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2: cycles each input vector is held before the output is sampled; legal range 1..15.
REQ-002 Parameter ROUNDS, default 4: number of full 4-vector sweeps per run; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  run request; sampled only in IDLE.
REQ-006 nand_a  output  1  operand A driven to the downstream NAND stage.
REQ-007 nand_b  output  1  operand B driven to the downstream NAND stage.
REQ-008 nand_y  input  1  NAND result returned from the downstream stage.
REQ-009 busy  output  1  high in any state other than IDLE.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  result of the last completed run; held until next accepted start.
REQ-012 err_count  output  8  mismatch count of current/last run, saturating.
REQ-013 fail_vec  output  4  bit i set if vector i ({a,b}=i) mismatched at least once.

Function
REQ-014 FSM states IDLE, DRIVE, CHECK, DONE; all outputs registered.
REQ-015 IDLE: nand_a=nand_b=0, busy=0; start=1 -> DRIVE with vector index 0 and round 0; err_count, fail_vec, pass cleared on that same edge.
REQ-016 DRIVE: nand_a=index[1], nand_b=index[0]; stays exactly SETTLE_CYCLES cycles, then -> CHECK.
REQ-017 CHECK (1 cycle): operands held; expected = ~(nand_a & nand_b); nand_y != expected -> err_count+1 (saturate at 255, no wrap) and fail_vec[index] set.
REQ-018 CHECK exit: index<3 -> index+1, DRIVE; index=3 and round<ROUNDS-1 -> index 0, round+1, DRIVE; index=3 and last round -> DONE.
REQ-019 DONE (1 cycle): done=1, pass=(err_count==0) including the final CHECK's result; operands return to 0; next state IDLE.
REQ-020 Latency: state DONE (done=1) begins exactly 4*ROUNDS*(SETTLE_CYCLES+1)+1 edges after the edge that samples start (49 with defaults).
REQ-021 start while busy (DRIVE/CHECK/DONE) is ignored; no restart, no counter clear.
REQ-022 start held high continuously: new run accepted on first IDLE cycle after DONE.
REQ-023 Index wraps 3->0 only at round boundary; round counter never exceeds ROUNDS-1.
REQ-024 err_count, fail_vec stay stable from DONE until the next accepted start.

Reset
REQ-025 rst=1 at any edge, including mid-run: next state IDLE, nand_a=nand_b=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0, internal counters 0.
REQ-026 rst has priority over start in the same cycle; run starts only on a later start with rst=0.

Verification
REQ-027 Ideal NAND model on nand_y, defaults, start pulse -> done at edge 49 after start, pass=1, err_count=0, fail_vec=4'b0000.
REQ-028 nand_y stuck at 1, defaults -> err_count=4, fail_vec=4'b1000, pass=0.
REQ-029 nand_y stuck at 0, defaults -> err_count=12, fail_vec=4'b0111, pass=0.
REQ-030 nand_y = AND of operands, ROUNDS=100 -> err_count saturates at 255 (400 mismatches), fail_vec=4'b1111, done at edge 1201.
REQ-031 Ideal model, start re-pulsed at edges 5 and 20 of run -> ignored, done still at edge 49, pass=1.
REQ-032 rst asserted at edge 20 of a stuck-at-1 run -> next cycle all outputs 0 and busy=0; fresh start then completes normally with err_count=4.

Source files
------------

// File: rtl/nand_exerciser.sv
// Built-in exerciser for a downstream 2-input NAND stage: sweeps all four operand
// vectors for ROUNDS rounds and records mismatches, a sticky per-vector map and a verdict.
module nand_exerciser #(
  parameter int SETTLE_CYCLES = 2,
  parameter int ROUNDS        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       nand_a,
  output logic       nand_b,
  input  logic       nand_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_e;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [7:0] ROUND_LAST  = 8'(ROUNDS - 1);

  state_e     state_q, state_d;
  logic [3:0] settle_q, settle_d;
  logic [1:0] index_q, index_d;
  logic [7:0] round_q, round_d;
  logic [7:0] err_q, err_d;
  logic [3:0] fail_q, fail_d;
  logic       pass_q, pass_d;
  logic       a_q, b_q, busy_q, done_q;
  logic       expected_y;

  assign expected_y = ~(index_q[1] & index_q[0]);

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves one unassigned;
    // without these defaults the case arms below would infer latches.
    state_d  = state_q;
    settle_d = settle_q;
    index_d  = index_q;
    round_d  = round_q;
    err_d    = err_q;
    fail_d   = fail_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = DRIVE;
          settle_d = 4'd0;
          index_d  = 2'd0;
          round_d  = 8'd0;
          err_d    = 8'd0;
          fail_d   = 4'd0;
          pass_d   = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = 4'd0;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      CHECK: begin
        if (nand_y != expected_y) begin
          if (err_q != 8'hFF) err_d = err_q + 8'd1;
          fail_d[index_q] = 1'b1;
        end
        // The vector index only wraps at a round boundary.
        if (index_q != 2'd3) begin
          index_d = index_q + 2'd1;
          state_d = DRIVE;
        end else if (round_q != ROUND_LAST) begin
          index_d = 2'd0;
          round_d = round_q + 8'd1;
          state_d = DRIVE;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        pass_d  = (err_q == 8'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples the
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= 4'd0;
      index_q  <= 2'd0;
      round_q  <= 8'd0;
      err_q    <= 8'd0;
      fail_q   <= 4'd0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      index_q  <= index_d;
      round_q  <= round_d;
      err_q    <= err_d;
      fail_q   <= fail_d;
      pass_q   <= pass_d;
    end
  end

  // Operand and status flops decode the current state, so they trail it by one edge;
  // done therefore rises one edge after the final CHECK has been counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      a_q    <= ((state_q == DRIVE) || (state_q == CHECK)) & index_q[1];
      b_q    <= ((state_q == DRIVE) || (state_q == CHECK)) & index_q[0];
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == DONE);
    end
  end

  assign nand_a    = a_q;
  assign nand_b    = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_nand_exerciser.sv
// Bench for nand_exerciser: an edge-count model of a run checked every cycle, plus
// literal end-of-run expectations for ideal, stuck-at, restart, reset and saturation cases.
module tb_nand_exerciser;

  localparam int S = 2;
  localparam int R = 4;
  localparam int L = 4 * R * (S + 1) + 1;   // edges from accepted start to done

  typedef enum {Y_IDEAL, Y_STUCK1, Y_STUCK0, Y_AND} y_mode_e;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, nand_a, nand_b, nand_y, busy, done, pass;
  logic [7:0] err_count;
  logic [3:0] fail_vec;
  y_mode_e    mode;

  logic       start100, a100, b100, y100, busy100, done100, pass100;
  logic [7:0] err100;
  logic [3:0] fv100;

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic y_of(input y_mode_e m, input logic a, input logic b);
    case (m)
      Y_IDEAL:  return !(a && b);
      Y_STUCK1: return 1'b1;
      Y_STUCK0: return 1'b0;
      default:  return a && b;
    endcase
  endfunction

  function automatic bit mism(input y_mode_e m, input int idx);
    logic a, b;
    a = idx[1];
    b = idx[0];
    return y_of(m, a, b) != !(a && b);
  endfunction

  always_comb nand_y = y_of(mode, nand_a, nand_b);
  always_comb y100   = y_of(Y_AND, a100, b100);

  nand_exerciser #(.SETTLE_CYCLES(S), .ROUNDS(R)) dut (
    .clk(clk), .rst(rst), .start(start), .nand_a(nand_a), .nand_b(nand_b),
    .nand_y(nand_y), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .fail_vec(fail_vec)
  );

  nand_exerciser #(.SETTLE_CYCLES(2), .ROUNDS(100)) dut_r100 (
    .clk(clk), .rst(rst), .start(start100), .nand_a(a100), .nand_b(b100),
    .nand_y(y100), .busy(busy100), .done(done100), .pass(pass100),
    .err_count(err100), .fail_vec(fv100)
  );

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is an edge count 'rel' from the accepted start; vector n is checked at
  // rel=(n+1)(S+1), operands show vector (rel-1)/(S+1), done/pass appear at rel=L.
  initial begin
    bit         running = 0;
    int         rel = 0, cnt = 0, idx = 0;
    logic [3:0] fv = 4'd0;
    logic       m_pass = 1'b0;
    logic       r_s, s_s, e_a, e_b;
    y_mode_e    m_s;
    forever begin
      @(posedge clk);
      r_s = rst; s_s = start; m_s = mode;
      @(negedge clk);
      if (r_s) begin
        running = 0; rel = 0; cnt = 0; fv = 4'd0; m_pass = 1'b0;
      end else if (!running) begin
        if (s_s) begin
          running = 1; rel = 0; cnt = 0; fv = 4'd0; m_pass = 1'b0;
        end
      end else begin
        rel++;
        if ((rel % (S + 1)) == 0 && rel <= L - 1) begin
          idx = (rel / (S + 1) - 1) % 4;
          if (mism(m_s, idx)) begin
            cnt++;
            fv[idx] = 1'b1;
          end
        end
        if (rel == L) m_pass = (cnt == 0);
      end
      e_a = 1'b0; e_b = 1'b0;
      if (running && rel >= 1 && rel <= L - 1) begin
        idx = ((rel - 1) / (S + 1)) % 4;
        e_a = idx[1];
        e_b = idx[0];
      end
      check("busy", busy, running && rel >= 1);
      check("done", done, running && rel == L);
      check("nand_a", nand_a, e_a);
      check("nand_b", nand_b, e_b);
      check("pass", pass, m_pass);
      check("err_count", err_count, (cnt > 255) ? 255 : cnt);
      check("fail_vec", fail_vec, fv);
      if (running && rel == L) running = 0;
    end
  end

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input bit use100, input int from, input int budget,
                           output int edges);
    bit seen = 0;
    edges = from;
    while (!seen && edges < budget) begin
      @(posedge clk);
      edges++;
      #1 seen = use100 ? done100 : done;
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL done_timeout: no done within %0d edges", budget);
    end
  endtask

  task automatic run_and_check(input string name, input y_mode_e m, input int exp_err,
                               input int exp_fv, input int exp_pass);
    int e;
    mode = m;
    do_start();
    wait_done(1'b0, 0, 200, e);
    check({name, "_done_edge"}, e, L);
    check({name, "_pass"}, pass, exp_pass);
    check({name, "_err"}, err_count, exp_err);
    check({name, "_fail_vec"}, fail_vec, exp_fv);
  endtask

  initial begin
    int e;
    rst = 1'b1; start = 1'b0; start100 = 1'b0; mode = Y_IDEAL;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy, nand_a, nand_b, done, pass, err_count, fail_vec}, 0);

    // start coinciding with reset must not launch a run
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("rst_beats_start_busy", busy, 0);

    run_and_check("ideal", Y_IDEAL, 0, 4'b0000, 1);
    run_and_check("stuck1", Y_STUCK1, 4, 4'b1000, 0);

    // re-pulsed start at edges 5 and 20 of an ideal run is ignored
    mode = Y_IDEAL;
    do_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (14) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(1'b0, 20, 200, e);
    check("repulse_done_edge", e, L);
    check("repulse_pass", pass, 1);

    run_and_check("stuck0", Y_STUCK0, 12, 4'b0111, 0);

    // reset at edge 20 of a stuck-at-1 run, then a fresh run
    mode = Y_STUCK1;
    do_start();
    repeat (19) @(posedge clk);
    #1 check("pre_rst_err", err_count, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 check("midrun_rst_outputs", {busy, nand_a, nand_b, done, pass, err_count, fail_vec}, 0);
    rst = 1'b0;
    run_and_check("after_rst", Y_STUCK1, 4, 4'b1000, 0);

    // start held high: next run accepted on first idle cycle after done
    mode = Y_IDEAL;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    wait_done(1'b0, 0, 200, e);
    check("held_first_done_edge", e, L);
    wait_done(1'b0, 0, 200, e);
    check("held_second_done_gap", e, L + 1);
    start = 1'b0;
    repeat (3) @(posedge clk);

    // 100 rounds with an AND stage: 400 mismatches saturate the counter
    @(negedge clk);
    start100 = 1'b1;
    @(posedge clk);
    #1 start100 = 1'b0;
    wait_done(1'b1, 0, 2000, e);
    check("r100_done_edge", e, 1201);
    check("r100_err_sat", err100, 255);
    check("r100_fail_vec", fv100, 4'b1111);
    check("r100_pass", pass100, 0);
    repeat (3) @(posedge clk);
    #1 check("r100_err_held", err100, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
